tone_sequencer: RTL
===================

Name: tone_sequencer

Overview:
Sequencer that drives the sine generator's `en` and `incr` inputs from a small programmable note table. Each table entry holds an increment (pitch) and a duration in clock cycles. On `start`, it plays entries 0..seq_len-1 in order, with an optional silent gap after each note, then pulses `done`. It sits between the control/vbd logic and the sine generator, so the generator can play melodies or sweeps without software timing.

Parameters:
N_NOTES, 8, note table depth (power of 2, >=2)
D_WIDTH, 8, increment width; matches the sine generator's incr
DUR_WIDTH, 16, note duration counter width
GAP_CYCLES, 4, silent cycles after each note; 0 = no gap
IDX_WIDTH, $clog2(N_NOTES), table index width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
wr_en  in  1  table write strobe
wr_addr  in  IDX_WIDTH  table entry written
wr_incr  in  D_WIDTH  increment stored at wr_addr
wr_dur  in  DUR_WIDTH  duration stored at wr_addr
seq_len  in  IDX_WIDTH+1  notes to play; sampled on accepted start
start  in  1  start pulse
stop  in  1  abort request
sg_en  out  1  to sine generator en
sg_incr  out  D_WIDTH  to sine generator incr
note_idx  out  IDX_WIDTH  index of current or last note
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all table entries=0; sg_en=0, sg_incr=0, note_idx=0, busy=0, done=0; latched length=0.
- States: IDLE, PLAY, GAP, DONE.
- IDLE: start=1 and stop=0 -> latch len=min(seq_len,N_NOTES).
  - len=0 -> DONE next cycle.
  - len>0 -> PLAY next cycle: note_idx=0, sg_incr=incr[0], sg_en=1, busy=1, timer loaded with dur[0].
- PLAY: sg_en=1 for exactly max(dur,1) cycles; dur=0 is treated as 1.
  - Timer expiry with GAP_CYCLES>0 -> GAP.
  - Timer expiry with GAP_CYCLES=0 -> next note, or DONE after the last note.
  - Back-to-back notes: sg_incr changes on the first cycle of the next note; sg_en stays high.
- GAP: sg_en=0 and sg_incr holds for GAP_CYCLES cycles.
  - Not last note -> PLAY with note_idx+1.
  - Last note -> DONE.
- DONE: done=1, sg_en=0, busy=0 for one cycle -> IDLE. Two back-to-back full runs never overlap done and sg_en.
- stop=1 in any state -> IDLE next cycle: sg_en=0, busy=0, no done pulse; note_idx and sg_incr hold.
  - stop wins over a simultaneous start.
- start while busy=1 is ignored.
- Writes take effect when wr_en=1 and busy=0; writes while busy=1 are dropped, so the table is stable during playback.
- Timer: down-counter loaded at note/gap entry, expiry when count==1. No wrap; the maximum note length is 2^DUR_WIDTH-1 cycles.
- Outputs are registered (no combinational path from inputs to outputs); latency from start to sg_en=1 is 1 cycle.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined: adds input `loop` (1 bit). When the last note's PLAY/GAP ends with loop=1, the block returns to PLAY at note 0 without entering DONE; busy stays 1 and no done pulse. loop=0 at that point completes normally. stop still aborts.
- Undefined: no `loop` port; the sequence is always one-shot.

Decomposition:
- Package tone_seq_pkg: state_t enum {IDLE, PLAY, GAP, DONE}; note_t packed struct {incr[D_WIDTH], dur[DUR_WIDTH]}; default width localparams.
- Sub-module seq_timer: loadable DUR_WIDTH down-counter with `load`, `value`, `expired`. Used for both note and gap timing.
- Table and FSM live in tone_sequencer.

Test Plan:
- Load {incr=4,dur=3},{incr=9,dur=2}, GAP_CYCLES=0, seq_len=2, start -> sg_en=1 for 5 consecutive cycles starting 1 cycle after start; sg_incr=4,4,4,9,9; done pulses the cycle after, busy falls with done.
- Same table, GAP_CYCLES=4 -> sg_en pattern 111 0000 11 0000, then done=1 for one cycle.
- seq_len=0 start -> done one cycle later, sg_en never asserts; seq_len=12 with N_NOTES=8 -> plays exactly 8 notes.
- Assert stop on the 2nd cycle of note 1 -> IDLE next cycle, sg_en=0, busy=0, no done; a new start replays from note 0.
- Assert rst=0 mid-PLAY, asynchronously between edges -> sg_en, busy, sg_incr go to 0 immediately; table reads back all zero. Writes with busy=1 leave the table unchanged.
- SEQ_LOOP_EN defined, loop=1, 2 notes -> note_idx sequence 0,1,0,1,... with no done; drop loop during the last note -> done after that note.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// Shared types and default widths for the tone sequencer slice.
package tone_seq_pkg;

  localparam int unsigned N_NOTES_DEF    = 8;
  localparam int unsigned D_WIDTH_DEF    = 8;
  localparam int unsigned DUR_WIDTH_DEF  = 16;
  localparam int unsigned GAP_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP,
    DONE
  } state_t;

  typedef struct packed {
    logic [D_WIDTH_DEF-1:0]   incr;
    logic [DUR_WIDTH_DEF-1:0] dur;
  } note_t;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; expired is high on the last cycle of a loaded interval.
module seq_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // A zero load is stretched to one cycle; the counter parks at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= (value == '0) ? WIDTH'(1) : value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/tone_sequencer.sv
// Plays a programmable note table into the sine generator's en/incr inputs.
// Optional SEQ_LOOP_EN adds a `loop` input that restarts the sequence instead of finishing.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter  int unsigned N_NOTES    = N_NOTES_DEF,
  parameter  int unsigned D_WIDTH    = D_WIDTH_DEF,
  parameter  int unsigned DUR_WIDTH  = DUR_WIDTH_DEF,
  parameter  int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  localparam int unsigned IDX_WIDTH  = $clog2(N_NOTES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0]   wr_incr,
  input  logic [DUR_WIDTH-1:0] wr_dur,
  input  logic [IDX_WIDTH:0]   seq_len,
  input  logic                 start,
  input  logic                 stop,
`ifdef SEQ_LOOP_EN
  input  logic                 loop,
`endif
  output logic                 sg_en,
  output logic [D_WIDTH-1:0]   sg_incr,
  output logic [IDX_WIDTH-1:0] note_idx,
  output logic                 busy,
  output logic                 done
);

  typedef struct packed {
    logic [D_WIDTH-1:0]   incr;
    logic [DUR_WIDTH-1:0] dur;
  } entry_t;

  entry_t note_table [N_NOTES];

  state_t               state, state_n;
  logic [IDX_WIDTH:0]   len_q, len_n, len_clamp;
  logic [IDX_WIDTH-1:0] idx_n, idx_next, adv_idx;
  logic [D_WIDTH-1:0]   incr_n;
  logic                 en_n, busy_n, done_n;
  logic                 last_note, advance, seq_end, loop_req;
  logic                 tmr_load, tmr_expired;
  logic [DUR_WIDTH-1:0] tmr_value;

`ifdef SEQ_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  assign len_clamp = (seq_len > (IDX_WIDTH+1)'(N_NOTES)) ? (IDX_WIDTH+1)'(N_NOTES) : seq_len;
  assign idx_next  = note_idx + IDX_WIDTH'(1);
  assign last_note = (({1'b0, note_idx} + (IDX_WIDTH+1)'(1)) == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_NOTES; i++) begin
        note_table[i] <= '0;
      end
    end else if (wr_en && !busy) begin
      note_table[wr_addr] <= '{incr: wr_incr, dur: wr_dur};
    end
  end

  seq_timer #(
    .WIDTH(DUR_WIDTH)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .expired(tmr_expired)
  );

  always_comb begin
    state_n   = state;
    len_n     = len_q;
    idx_n     = note_idx;
    incr_n    = sg_incr;
    en_n      = sg_en;
    busy_n    = busy;
    done_n    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    advance   = 1'b0;
    adv_idx   = '0;
    seq_end   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          len_n = len_clamp;
          if (len_clamp == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      PLAY: begin
        if (tmr_expired) begin
          if (GAP_CYCLES != 0) begin
            state_n   = GAP;
            en_n      = 1'b0;
            tmr_load  = 1'b1;
            tmr_value = DUR_WIDTH'(GAP_CYCLES);
          end else if (!last_note) begin
            advance = 1'b1;
            adv_idx = idx_next;
          end else begin
            seq_end = 1'b1;
          end
        end
      end
      GAP: begin
        if (tmr_expired) begin
          if (!last_note) begin
            advance = 1'b1;
            adv_idx = idx_next;
          end else begin
            seq_end = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // End of the last note either wraps to note 0 or finishes with a done pulse.
    if (seq_end) begin
      if (loop_req) begin
        advance = 1'b1;
        adv_idx = '0;
      end else begin
        state_n = DONE;
        en_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
    end

    if (advance) begin
      state_n   = PLAY;
      idx_n     = adv_idx;
      incr_n    = note_table[adv_idx].incr;
      en_n      = 1'b1;
      busy_n    = 1'b1;
      tmr_load  = 1'b1;
      tmr_value = note_table[adv_idx].dur;
    end

    // Abort overrides everything; index and pitch hold their last values.
    if (stop) begin
      state_n  = IDLE;
      len_n    = len_q;
      idx_n    = note_idx;
      incr_n   = sg_incr;
      en_n     = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      len_q    <= '0;
      note_idx <= '0;
      sg_incr  <= '0;
      sg_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      len_q    <= len_n;
      note_idx <= idx_n;
      sg_incr  <= incr_n;
      sg_en    <= en_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule
